alu_array_pipe: RTL and testbench

- Parametrised successor to the fixed two-channel 4-bit user-project ALU driven from mprj_io.
- CHANNELS independent WIDTH-bit ALU lanes share one valid/ready handshake, one operation slot, and a fixed two-stage pipeline.
- Each lane keeps its own accumulator. A shared saturating counter records carry/borrow events.
- Sits inside the user project wrapper between the GPIO input bank and the GPIO output bank.

---
 rtl/alu_array_pipe.sv | 144 ++++++++++++++
 tb/tb_alu_array_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_array_pipe.sv
// Multi-lane ALU with per-lane accumulators, a shared saturating carry-event counter and a
// two-stage valid/ready pipeline (S1 compute register, S2 output register).
module alu_array_pipe #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned CNTW     = 8
) (
   input  logic                         clock,
   input  logic                         resetb,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*WIDTH-1:0]    a,
   input  logic [CHANNELS*WIDTH-1:0]    b,
   input  logic [CHANNELS*3-1:0]        op,
   input  logic                         acc_clear,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*(WIDTH+1)-1:0] result,
   output logic [CHANNELS-1:0]          zero,
   output logic [CNTW-1:0]              carry_cnt
);

   localparam int unsigned RW = WIDTH + 1;

   typedef enum logic [2:0] {
      OpAdd  = 3'b000,
      OpSub  = 3'b001,
      OpAnd  = 3'b010,
      OpOr   = 3'b011,
      OpXor  = 3'b100,
      OpNand = 3'b101,
      OpAcc  = 3'b110,
      OpInv  = 3'b111
   } op_e;

   logic                      r_s1_valid;
   logic [CHANNELS*RW-1:0]    r_s1_res;
   logic                      r_s2_valid;
   logic [CHANNELS*RW-1:0]    r_s2_res;
   logic [CHANNELS-1:0]       r_zero;
   logic [CHANNELS*WIDTH-1:0] r_acc;
   logic [CNTW-1:0]           r_cnt;

   logic                      w_s2_adv;
   logic                      w_s1_adv;
   logic                      w_accept;
   logic [CHANNELS*RW-1:0]    w_res;
   logic [CHANNELS*WIDTH-1:0] w_acc_d;
   logic [CHANNELS-1:0]       w_msb;
   logic [CHANNELS-1:0]       w_s1_zero;
   logic                      w_cnt_inc;
   logic [WIDTH-1:0]          w_la;
   logic [WIDTH-1:0]          w_lb;
   logic [WIDTH-1:0]          w_base;
   logic [RW-1:0]             w_lr;
   op_e                       w_lop;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = w_s2_adv || !r_s1_valid;
   assign in_ready = !r_s1_valid || w_s2_adv;
   assign w_accept = in_valid && in_ready;

   // Lane datapath; a clear coinciding with ACC zeroes the base before the add.
   always_comb begin
      w_res   = '0;
      w_acc_d = r_acc;
      w_msb   = '0;
      w_la    = '0;
      w_lb    = '0;
      w_base  = '0;
      w_lr    = '0;
      w_lop   = OpAdd;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         w_la   = a[i*WIDTH +: WIDTH];
         w_lb   = b[i*WIDTH +: WIDTH];
         w_lop  = op_e'(op[i*3 +: 3]);
         w_base = acc_clear ? '0 : r_acc[i*WIDTH +: WIDTH];
         unique case (w_lop)
            OpAdd:   w_lr = {1'b0, w_la} + {1'b0, w_lb};
            OpSub:   w_lr = {1'b0, w_la} - {1'b0, w_lb};
            OpAnd:   w_lr = {1'b0, w_la & w_lb};
            OpOr:    w_lr = {1'b0, w_la | w_lb};
            OpXor:   w_lr = {1'b0, w_la ^ w_lb};
            OpNand:  w_lr = {1'b0, ~(w_la & w_lb)};
            OpAcc:   w_lr = {1'b0, w_base} + {1'b0, w_la};
            OpInv:   w_lr = {1'b0, ~w_la};
            default: w_lr = '0;
         endcase
         w_res[i*RW +: RW] = w_lr;
         w_msb[i]          = w_lr[WIDTH];
         if (w_accept && (w_lop == OpAcc)) begin
            w_acc_d[i*WIDTH +: WIDTH] = w_lr[WIDTH-1:0];
         end else if (acc_clear) begin
            w_acc_d[i*WIDTH +: WIDTH] = '0;
         end
      end
   end

   always_comb begin
      w_s1_zero = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         w_s1_zero[i] = (r_s1_res[i*RW +: WIDTH] == '0);
      end
   end

   assign w_cnt_inc = (|w_msb) && (r_cnt != {CNTW{1'b1}});

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_s1_valid <= 1'b0;
         r_s1_res   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_res   <= '0;
         r_zero     <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
      end else begin
         r_acc <= w_acc_d;
         if (w_s1_adv) begin
            r_s1_valid <= w_accept;
         end
         if (w_accept) begin
            r_s1_res <= w_res;
            if (w_cnt_inc) begin
               r_cnt <= r_cnt + CNTW'(1);
            end
         end
         // S2 only reloads when it advances, so a stalled result stays frozen.
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_res <= r_s1_res;
               r_zero   <= w_s1_zero;
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_s2_res;
   assign zero      = r_zero;
   assign carry_cnt = r_cnt;

endmodule

// File: tb/tb_alu_array_pipe.sv
// Directed bench for alu_array_pipe with a scoreboard of expected output bundles.
module tb_alu_array_pipe;

   logic       clock;
   logic       resetb;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [5:0] op;
   logic       acc_clear;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] result;
   logic [1:0] zero;
   logic [7:0] carry_cnt;

   logic       in_ready2;
   logic       out_valid2;
   logic [9:0] result2;
   logic [1:0] zero2;
   logic [1:0] carry_cnt2;

   int n_total = 0;
   int n_pass  = 0;

   logic [11:0] q[$];
   logic [3:0]  m_acc[2];
   int          m_cnt8;
   int          m_cnt2;

   alu_array_pipe #(.WIDTH(4), .CHANNELS(2), .CNTW(8)) u_dut (
      .clock(clock), .resetb(resetb), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_clear(acc_clear), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .carry_cnt(carry_cnt)
   );

   alu_array_pipe #(.WIDTH(4), .CHANNELS(2), .CNTW(2)) u_dut_sat (
      .clock(clock), .resetb(resetb), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .op(op), .acc_clear(acc_clear), .out_valid(out_valid2),
      .out_ready(out_ready), .result(result2), .zero(zero2), .carry_cnt(carry_cnt2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [4:0] calc(input logic [2:0] o, input logic [3:0] x,
                                       input logic [3:0] y, input logic [3:0] base);
      int s;
      case (o)
         3'd0: begin s = int'(x) + int'(y); return 5'(s); end
         3'd1: return {x < y, 4'(x - y)};
         3'd2: return {1'b0, x & y};
         3'd3: return {1'b0, x | y};
         3'd4: return {1'b0, x ^ y};
         3'd5: return {1'b0, ~(x & y)};
         3'd6: begin s = int'(base) + int'(x); return 5'(s); end
         default: return {1'b0, ~x};
      endcase
   endfunction

   task automatic flush_model();
      q.delete();
      m_acc[0] = '0;
      m_acc[1] = '0;
      m_cnt8   = 0;
      m_cnt2   = 0;
   endtask

   // Scoreboard and model; transfers seen at the negedge complete on the next rising edge.
   always @(negedge clock) begin
      logic [11:0] e;
      logic [4:0]  r;
      logic [3:0]  base;
      logic        any;
      if (resetb) begin
         check("carry_cnt_model", carry_cnt, m_cnt8);
         check("carry_cnt_sat_model", carry_cnt2, m_cnt2);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", out_valid, 0);
            end else begin
               e = q.pop_front();
               check("sb_result", result, e[9:0]);
               check("sb_zero", zero, e[11:10]);
            end
         end
         if (in_valid && in_ready) begin
            any = 1'b0;
            e   = '0;
            for (int l = 0; l < 2; l++) begin
               base = acc_clear ? 4'd0 : m_acc[l];
               r = calc(op[l*3 +: 3], a[l*4 +: 4], b[l*4 +: 4], base);
               if (op[l*3 +: 3] == 3'd6) m_acc[l] = r[3:0];
               else if (acc_clear) m_acc[l] = '0;
               e[l*5 +: 5] = r;
               e[10 + l]   = (r[3:0] == 4'd0);
               any = any | r[4];
            end
            q.push_back(e);
            if (any && m_cnt8 < 255) m_cnt8++;
            if (any && m_cnt2 < 3) m_cnt2++;
         end else if (acc_clear) begin
            m_acc[0] = '0;
            m_acc[1] = '0;
         end
      end
   end

   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [5:0] opv,
                       input logic clr);
      bit got;
      got = 1'b0;
      a = av; b = bv; op = opv; acc_clear = clr; in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("accept_timeout", in_ready, 1);
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      acc_clear = 1'b0;
   endtask

   task automatic wait_out(output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         n++;
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("output_timeout", out_valid, 1);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   int          lat;
   int          exp_sat[5] = '{1, 2, 3, 3, 3};
   logic [4:0]  exp_acc[6] = '{5'b00111, 5'b01110, 5'b10101, 5'b00101, 5'b00010, 5'b00011};
   logic [7:0]  acc_a[6]   = '{8'h07, 8'h07, 8'h07, 8'h00, 8'h02, 8'h01};
   logic        acc_clr[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      in_valid = 1'b0; a = '0; b = '0; op = '0; acc_clear = 1'b0; out_ready = 1'b1;
      resetb = 1'b1;
      flush_model();
      #2 resetb = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 0);
      check("rst_carry_cnt", carry_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clock);
      #1 resetb = 1'b1;
      step();

      // ADD with carry on lane0, zero result on lane1
      send({4'd0, 4'd9}, {4'd0, 4'd9}, {3'd0, 3'd0}, 1'b0);
      wait_out(lat);
      check("add_latency", lat, 2);
      check("add_result", result, {5'b00000, 5'b10010});
      check("add_zero", zero, 2'b10);
      check("add_carry_cnt", carry_cnt, 1);
      step();

      // SUB with borrow, NAND
      send({4'b1100, 4'd3}, {4'b1010, 4'd5}, {3'd5, 3'd1}, 1'b0);
      wait_out(lat);
      check("sub_nand_result", result, {5'b00111, 5'b11110});
      check("sub_nand_zero", zero, 2'b00);
      check("sub_carry_cnt", carry_cnt, 2);
      step();

      // Back-pressure: two accepts fill the pipe, the third waits
      out_ready = 1'b0;
      send({4'hF, 4'd1}, {4'h5, 4'd2}, {3'd4, 3'd0}, 1'b0);
      send({4'h8, 4'hF}, {4'h1, 4'h3}, {3'd3, 3'd2}, 1'b0);
      a = {4'h8, 4'h5}; b = {4'h8, 4'h0}; op = {3'd0, 3'd7}; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_frozen_result", result, {5'b01010, 5'b00011});
      end
      step();
      out_ready = 1'b1;
      @(negedge clock);
      check("bp_drain_1", out_valid, 1);
      check("bp_in_ready_high", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clock);
      check("bp_drain_2", out_valid, 1);
      @(negedge clock);
      check("bp_drain_3", out_valid, 1);
      check("bp_b3_result", result, {5'b10000, 5'b01010});
      check("bp_b3_zero", zero, 2'b10);
      step();

      // Accumulator: 7 three times (wraps), read back 5, then clear with ACC 2, then +1
      for (int k = 0; k < 6; k++) begin
         send({4'd0, acc_a[k][3:0]}, 8'h00, {3'd0, 3'd6}, acc_clr[k]);
         wait_out(lat);
         check("acc_result", result[4:0], exp_acc[k]);
         step();
      end

      // Saturating counter on the CNTW=2 instance
      resetb = 1'b0;
      flush_model();
      step();
      resetb = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         send({4'd0, 4'd9}, {4'd0, 4'd9}, {3'd0, 3'd0}, 1'b0);
         check("sat_carry_cnt", carry_cnt2, exp_sat[k]);
      end
      repeat (3) @(negedge clock);
      step();

      // Reset with two bundles in flight
      out_ready = 1'b0;
      send({4'd0, 4'd4}, 8'h00, {3'd0, 3'd6}, 1'b0);
      send({4'd0, 4'd9}, {4'd0, 4'd9}, {3'd0, 3'd0}, 1'b0);
      check("inflight_out_valid", out_valid, 1);
      #2 resetb = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_carry_cnt", carry_cnt, 0);
      check("async_rst_carry_cnt_sat", carry_cnt2, 0);
      flush_model();
      step();
      resetb = 1'b1;
      out_ready = 1'b1;
      step();
      send({4'd2, 4'd3}, {4'd1, 4'd0}, {3'd1, 3'd6}, 1'b0);
      wait_out(lat);
      check("post_rst_result", result, {5'b00001, 5'b00011});
      check("post_rst_zero", zero, 2'b00);
      check("post_rst_carry_cnt", carry_cnt, 0);
      step();

      repeat (4) @(negedge clock);
      check("sb_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
